// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, MMIO offsets, bus widths.
package dmem_responder_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned BusAddrW = 32;
  localparam int unsigned WaitCntW = 4;

  localparam logic [BusAddrW-1:0] MmioTxOff     = 32'd0;
  localparam logic [BusAddrW-1:0] MmioStatusOff = 32'd1;
  localparam logic [BusAddrW-1:0] MmioCyclesOff = 32'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_sram.sv
// Word-addressed 32-bit RAM: synchronous write, combinational read, contents not reset.
module dmem_sram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus responder: one request at a time, WAIT_CYCLES wait states, one-cycle response.
// Backs a word RAM plus an MMIO window (console TX byte, TX status, free-running cycle counter).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned          ADDR_W      = 10,
  parameter int unsigned          WAIT_CYCLES = 2,
  parameter logic [BusAddrW-1:0]  MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [BusAddrW-1:0] req_addr,
  input  logic [DataW-1:0]    req_wdata,
  output logic                resp_valid,
  output logic [DataW-1:0]    resp_rdata,
  output logic                resp_err,
  output logic                busy,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready
);

  state_e                state_q;
  logic [WaitCntW-1:0]   wait_cnt_q;
  logic                  write_q;
  logic [BusAddrW-1:0]   addr_q;
  logic [DataW-1:0]      wdata_q;
  logic                  resp_valid_q;
  logic [DataW-1:0]      resp_rdata_q;
  logic                  resp_err_q;
  logic                  tx_valid_q;
  logic [7:0]            tx_data_q;
  logic [DataW-1:0]      cycles_q;

  logic                  in_ram, is_tx, is_status, is_cycles;
  logic                  tx_store, tx_stall, commit, ram_we;
  logic [DataW-1:0]      ram_rdata, rd_data;
  logic                  rd_err;

  assign in_ram    = (addr_q >> ADDR_W) == '0;
  assign is_tx     = addr_q == MMIO_BASE + MmioTxOff;
  assign is_status = addr_q == MMIO_BASE + MmioStatusOff;
  assign is_cycles = addr_q == MMIO_BASE + MmioCyclesOff;

  // A TX store only stalls when the previous byte is still pending and the sink is not taking it.
  assign tx_store = write_q && !in_ram && is_tx;
  assign tx_stall = tx_store && tx_valid_q && !tx_ready;
  assign commit   = (state_q == StWait) && (wait_cnt_q == '0) && !tx_stall;
  assign ram_we   = commit && write_q && in_ram;

  dmem_sram #(
    .AddrW (ADDR_W)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (addr_q[ADDR_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (in_ram) begin
      rd_data = ram_rdata;
    end else if (is_tx) begin
      rd_data = {24'b0, tx_data_q};
    end else if (is_status) begin
      rd_data = {31'b0, ~tx_valid_q};
    end else if (is_cycles) begin
      rd_data = cycles_q;
    end else begin
      rd_err = 1'b1;
    end
    if (write_q) begin
      rd_data = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      cycles_q     <= '0;
    end else begin
      cycles_q     <= cycles_q + 32'd1;
      // Response pulse is registered off the RESP state, landing WAIT_CYCLES+2 edges after accept.
      resp_valid_q <= (state_q == StResp);
      if (tx_valid_q && tx_ready) begin
        tx_valid_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q    <= StWait;
            write_q    <= req_write;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            wait_cnt_q <= WaitCntW'(WAIT_CYCLES);
          end
        end
        StWait: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end else if (commit) begin
            state_q      <= StResp;
            resp_rdata_q <= rd_data;
            resp_err_q   <= rd_err;
            if (tx_store) begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= wdata_q[7:0];
            end
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table with a response scoreboard, plus
// hand-written TX back-pressure, mid-request reset, cycle-counter and zero-wait-state sequences.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam int          WA = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: WAIT_CYCLES=2
  logic        a_valid = 0, a_write = 0, a_tx_ready = 0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_resp_valid, a_resp_err, a_busy, a_tx_valid;
  logic [31:0] a_rdata;
  logic [7:0]  a_tx_data;

  // DUT B: WAIT_CYCLES=0
  logic        b_valid = 0, b_write = 0, b_tx_ready = 1;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_resp_valid, b_resp_err, b_busy, b_tx_valid;
  logic [31:0] b_rdata;
  logic [7:0]  b_tx_data;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(WA), .MMIO_BASE(MB)) u_dut_a (
    .clk(clk), .reset(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_rdata),
    .resp_err(a_resp_err), .busy(a_busy), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
    .tx_ready(a_tx_ready)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .MMIO_BASE(MB)) u_dut_b (
    .clk(clk), .reset(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_rdata),
    .resp_err(b_resp_err), .busy(b_busy), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
    .tx_ready(b_tx_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          chk_data;
    bit          chk_lat;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] last_rdata;
  int          last_acc;

  always @(negedge clk) begin
    if (rst_n && a_resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("resp_err", {31'b0, a_resp_err}, {31'b0, e.err});
        if (e.chk_data) check("resp_rdata", a_rdata, e.rdata);
        if (e.chk_lat) check("resp_latency", cyc - e.acc, WA + 2);
        last_rdata = a_rdata;
        last_acc   = e.acc;
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit chk_data, input bit chk_lat);
    int t = 0;
    sb_t e;
    @(negedge clk);
    a_valid = 1; a_write = wr; a_addr = addr; a_wdata = wdata;
    while (!a_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("accept_timeout", 32'd1, 32'd0);
    end else begin
      e.rdata = exp_rd; e.err = exp_err; e.acc = cyc + 1;
      e.chk_data = chk_data; e.chk_lat = chk_lat;
      sb.push_back(e);
    end
    @(negedge clk);
    a_valid = 0;
  endtask

  task automatic wait_resp();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input bit chk_data);
    issue(wr, addr, wdata, exp_rd, exp_err, chk_data, 1'b1);
    wait_resp();
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] v1, v2;
    int a1, a2;

    vecs[0]  = '{1'b1, 32'd5,      32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'd5,      32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'd0,      32'h0000_1234, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'd0,      32'h0,         32'h0000_1234, 1'b0};
    vecs[4]  = '{1'b1, 32'd1023,   32'hA5A5_5A5A, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 32'd1023,   32'h0,         32'hA5A5_5A5A, 1'b0};
    vecs[6]  = '{1'b0, 32'd1024,   32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b0, MB + 32'd7, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'd0,      32'h0,         32'h0000_1234, 1'b0};
    vecs[9]  = '{1'b1, 32'd1024,   32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'd0,      32'h0,         32'h0000_1234, 1'b0};
    vecs[11] = '{1'b1, MB + 32'd1, 32'h0000_0123, 32'h0,         1'b0};
    vecs[12] = '{1'b1, MB + 32'd2, 32'h0000_0456, 32'h0,         1'b0};
    vecs[13] = '{1'b0, MB - 32'd1, 32'h0,         32'h0,         1'b1};
    vecs[14] = '{1'b1, MB + 32'd3, 32'h1,         32'h0,         1'b1};
    vecs[15] = '{1'b0, 32'd5,      32'h0,         32'hDEAD_BEEF, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, a_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
    check("rst_busy", {31'b0, a_busy}, 32'd0);
    check("rst_tx_valid", {31'b0, a_tx_valid}, 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 1'b1);
    end

    // TX back-pressure: first store lands, second stalls until the sink handshakes.
    a_tx_ready = 0;
    xact(1'b1, MB, 32'h0000_0041, 32'h0, 1'b0, 1'b1);
    check("tx_valid_first", {31'b0, a_tx_valid}, 32'd1);
    check("tx_data_first", {24'b0, a_tx_data}, 32'h41);
    xact(1'b0, MB + 32'd1, 32'h0, 32'h0, 1'b0, 1'b1);
    xact(1'b0, MB, 32'h0, 32'h41, 1'b0, 1'b1);
    issue(1'b1, MB, 32'h0000_0042, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("tx_stall_busy", {31'b0, a_busy}, 32'd1);
    end
    check("tx_stall_data", {24'b0, a_tx_data}, 32'h41);
    a_tx_ready = 1;
    @(negedge clk);
    a_tx_ready = 0;
    check("tx_valid_second", {31'b0, a_tx_valid}, 32'd1);
    check("tx_data_second", {24'b0, a_tx_data}, 32'h42);
    wait_resp();
    xact(1'b0, MB + 32'd1, 32'h0, 32'h0, 1'b0, 1'b1);
    a_tx_ready = 1;
    @(negedge clk);
    a_tx_ready = 0;
    check("tx_drained", {31'b0, a_tx_valid}, 32'd0);
    xact(1'b0, MB + 32'd1, 32'h0, 32'h1, 1'b0, 1'b1);

    // Zero-wait-state build under continuous requests: accept every third cycle.
    @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      if (k == 0) b_valid = 1;
      check("b_req_ready", {31'b0, b_ready}, {31'b0, (k % 3) == 0});
      check("b_resp_valid", {31'b0, b_resp_valid}, {31'b0, ((k % 3) == 0) && (k >= 3)});
      @(negedge clk);
    end
    b_valid = 0;

    // Reset in the wait states of a store: dropped, no response, RAM keeps old word.
    xact(1'b1, 32'd9, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
    a_tx_ready = 0;
    xact(1'b1, MB, 32'h0000_0055, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 32'd9, 32'h2222_2222, 32'h0, 1'b0, 1'b1, 1'b1);
    check("pre_reset_busy", {31'b0, a_busy}, 32'd1);
    rst_n = 0;
    sb.delete();
    #1;
    check("mid_rst_busy", {31'b0, a_busy}, 32'd0);
    check("mid_rst_ready", {31'b0, a_ready}, 32'd1);
    check("mid_rst_tx_valid", {31'b0, a_tx_valid}, 32'd0);
    check("mid_rst_tx_data", {24'b0, a_tx_data}, 32'd0);
    check("mid_rst_err", {31'b0, a_resp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_resp", {31'b0, a_resp_valid}, 32'd0);
    end
    xact(1'b0, 32'd9, 32'h0, 32'h1111_1111, 1'b0, 1'b1);

    // Cycle counter: difference tracks the spacing of the two accepts.
    xact(1'b0, MB + 32'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    v1 = last_rdata; a1 = last_acc;
    repeat (7) @(negedge clk);
    xact(1'b0, MB + 32'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    v2 = last_rdata; a2 = last_acc;
    check("cycles_gap_min", {31'b0, (a2 - a1) >= (7 + WA + 3)}, 32'd1);
    check("cycles_delta", v2 - v1, a2 - a1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
